// File: rtl/pc_gen_ras.sv
// Fetch-stage program counter with next-PC selection and a circular return-address stack.
// The RAS predicts returns in a single cycle; when full, the oldest entry is overwritten.
module pc_gen_ras #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned RAS_DEPTH    = 8,
  parameter int unsigned INSTR_BYTES  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        flush_i,
  input  logic [PC_WIDTH-1:0]         flush_target_i,
  input  logic                        jalr_instr_i,
  input  logic [PC_WIDTH-1:0]         jta_jalr_i,
  input  logic                        ret_i,
  input  logic                        call_i,
  input  logic                        jump_taken_i,
  input  logic [PC_WIDTH-1:0]         imm_ext_i,
  output logic [PC_WIDTH-1:0]         pc_o,
  output logic [PC_WIDTH-1:0]         pc_plus4_o,
  output logic [$clog2(RAS_DEPTH):0]  ras_count_o,
  output logic                        ras_empty_o,
  output logic                        ras_full_o,
  output logic                        ras_overflow_o,
  output logic                        ras_underflow_o,
  output logic                        misalign_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_RST   = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(INSTR_BYTES);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PTR_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;
  logic                r_underflow;
  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];

  logic [PC_WIDTH-1:0] w_pc_plus;
  logic [PC_WIDTH-1:0] w_jalr_tgt;
  logic [PC_WIDTH-1:0] w_ras_top;
  logic [PTR_W-1:0]    w_top_idx;
  logic                w_empty;
  logic                w_full;
  logic                w_adv;
  logic                w_pop_hit;

  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                w_overflow_nxt;
  logic                w_underflow_nxt;
  logic                w_wr_en;
  logic [PTR_W-1:0]    w_wr_idx;

  assign w_pc_plus  = r_pc + PC_STEP;
  assign w_jalr_tgt = {jta_jalr_i[PC_WIDTH-1:1], 1'b0};
  assign w_top_idx  = r_ptr - PTR_ONE;
  assign w_ras_top  = r_ras[w_top_idx];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_adv      = en_i & ~flush_i;
  assign w_pop_hit  = ret_i & ~w_empty;

  // Next-PC priority: flush, stall, JALR, RAS return, PC-relative, sequential.
  always_comb begin
    w_pc_nxt = w_pc_plus;
    if (flush_i) begin
      w_pc_nxt = flush_target_i;
    end else if (!en_i) begin
      w_pc_nxt = r_pc;
    end else if (jalr_instr_i) begin
      w_pc_nxt = w_jalr_tgt;
    end else if (w_pop_hit) begin
      w_pc_nxt = w_ras_top;
    end else if (jump_taken_i) begin
      w_pc_nxt = r_pc + imm_ext_i;
    end
  end

  // RAS bookkeeping; a simultaneous call/return on a non-empty stack swaps the top in place.
  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_count_nxt     = r_count;
    w_overflow_nxt  = 1'b0;
    w_underflow_nxt = 1'b0;
    w_wr_en         = 1'b0;
    w_wr_idx        = r_ptr;
    if (w_adv) begin
      w_underflow_nxt = ret_i & w_empty;
      if (call_i && w_pop_hit) begin
        w_wr_en  = 1'b1;
        w_wr_idx = w_top_idx;
      end else if (call_i) begin
        w_wr_en        = 1'b1;
        w_wr_idx       = r_ptr;
        w_ptr_nxt      = r_ptr + PTR_ONE;
        w_overflow_nxt = w_full;
        if (!w_full) begin
          w_count_nxt = r_count + CNT_ONE;
        end
      end else if (w_pop_hit) begin
        w_ptr_nxt   = w_top_idx;
        w_count_nxt = r_count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc        <= PC_RST;
      r_ptr       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        r_ras[i] <= '0;
      end
    end else begin
      r_pc        <= w_pc_nxt;
      r_ptr       <= w_ptr_nxt;
      r_count     <= w_count_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
      if (w_wr_en) begin
        r_ras[w_wr_idx] <= w_pc_plus;
      end
    end
  end

  assign pc_o            = r_pc;
  assign pc_plus4_o      = w_pc_plus;
  assign ras_count_o     = r_count;
  assign ras_empty_o     = w_empty;
  assign ras_full_o      = w_full;
  assign ras_overflow_o  = r_overflow;
  assign ras_underflow_o = r_underflow;
  assign misalign_o      = (r_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen_ras.sv
// Scoreboard bench for pc_gen_ras: a queue-based RAS model predicts each cycle's outputs,
// and an independent monitor compares them one cycle later.
module tb_pc_gen_ras;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_i, en_i, flush_i, jalr_instr_i, ret_i, call_i, jump_taken_i;
  logic [31:0] flush_target_i, jta_jalr_i, imm_ext_i;
  logic [31:0] pc_o, pc_plus4_o;
  logic [3:0]  ras_count_o;
  logic        ras_empty_o, ras_full_o, ras_overflow_o, ras_underflow_o, misalign_o;

  pc_gen_ras dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
    .flush_target_i(flush_target_i), .jalr_instr_i(jalr_instr_i), .jta_jalr_i(jta_jalr_i),
    .ret_i(ret_i), .call_i(call_i), .jump_taken_i(jump_taken_i), .imm_ext_i(imm_ext_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .ras_count_o(ras_count_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .ras_overflow_o(ras_overflow_o),
    .ras_underflow_o(ras_underflow_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the model's prediction for after the edge.
  task automatic step(input logic rs, input logic en, input logic fl, input logic [31:0] ft,
                      input logic jl, input logic [31:0] jt, input logic rt, input logic cl,
                      input logic jp, input logic [31:0] im);
    exp_t e;
    logic [31:0] ret_addr;
    bit nonempty;
    @(negedge clk);
    rst_i = rs; en_i = en; flush_i = fl; flush_target_i = ft; jalr_instr_i = jl;
    jta_jalr_i = jt; ret_i = rt; call_i = cl; jump_taken_i = jp; imm_ext_i = im;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (rs) begin
      m_pc = 32'hBFC00000;
      m_ras.delete();
    end else if (fl) begin
      m_pc = ft;
    end else if (en) begin
      nonempty = (m_ras.size() > 0);
      ret_addr = m_pc + 32'd4;
      e.unf    = rt && !nonempty;
      if (jl)                   m_pc = jt & ~32'd1;
      else if (rt && nonempty)  m_pc = m_ras[m_ras.size()-1];
      else if (jp)              m_pc = m_pc + im;
      else                      m_pc = m_pc + 32'd4;
      if (cl && rt && nonempty) begin
        m_ras[m_ras.size()-1] = ret_addr;
      end else if (cl) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          e.ovf = 1'b1;
        end
        m_ras.push_back(ret_addr);
      end else if (rt && nonempty) begin
        void'(m_ras.pop_back());
      end
    end
    e.pc  = m_pc;
    e.cnt = m_ras.size();
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input logic [31:0] a);
    step(0, 1, 1, a, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every registered and combinational output against the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("pc_plus4_o", pc_plus4_o, e.pc + 32'd4);
        chk("ras_count_o", 32'(ras_count_o), 32'(e.cnt));
        chk("ras_empty_o", 32'(ras_empty_o), 32'(e.cnt == 0));
        chk("ras_full_o", 32'(ras_full_o), 32'(e.cnt == DEPTH));
        chk("ras_overflow_o", 32'(ras_overflow_o), 32'(e.ovf));
        chk("ras_underflow_o", 32'(ras_underflow_o), 32'(e.unf));
        chk("misalign_o", 32'(misalign_o), 32'(e.pc[1:0] != 2'b00));
      end
    end
  end

  initial begin
    int budget;
    rst_i = 1'b1; en_i = 0; flush_i = 0; flush_target_i = 0; jalr_instr_i = 0;
    jta_jalr_i = 0; ret_i = 0; call_i = 0; jump_taken_i = 0; imm_ext_i = 0;
    m_pc = 32'hBFC00000;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(4);                                        // 04, 08, 0C, 10
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFF0);  // branch back to BFC00000
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40);
    redirect(32'h100);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);             // call at 100
    redirect(32'h200);
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);             // ret at 200 -> 104
    redirect(32'h1000);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);             // ret on empty: underflow
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 32'h3000, 0, 0, 1, 0, 0, 0);      // flush while stalled with ret
    step(0, 1, 0, 0, 1, 32'h203, 0, 0, 1, 32'h80);  // jalr wins over branch
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);             // call+ret, non-empty
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);             // call+ret, empty
    redirect(32'hFFFFFFFC);
    idle(2);                                        // wrap to 0
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);             // reset mid-stall
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
           $urandom & ~32'd3, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           32'($signed(32'($urandom_range(0, 255)) - 32'd128)) << 2);
    end
    @(negedge clk);
    rst_i = 0; en_i = 0; flush_i = 0; call_i = 0; ret_i = 0;
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
